// File: rtl/fifo_top.sv
// fifo_top: single-clock DEPTH x DATA_W FIFO; wr/data_in push, rd pops into registered data_out, fifo_full/fifo_empty status from wrap-bit pointers
module fifo_top #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wptr, rptr;
  logic we, re;
  always_comb begin
    fifo_empty = wptr == rptr;
    fifo_full = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
    we = wr && !fifo_full;
    re = rd && !fifo_empty;
  end
  always_ff @(posedge clk)
    if (we) mem[wptr[ADDR_W-1:0]] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      data_out <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) begin
        data_out <= mem[rptr[ADDR_W-1:0]];
        rptr <= rptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_fifo_top.sv
// tb_fifo_top: randomized scoreboard bench for fifo_top against a queue-based reference model
module tb_fifo_top;
  logic clk, rst, wr, rd;
  logic [7:0] data_in, data_out;
  logic fifo_full, fifo_empty;
  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       e;
    logic [3:0] w;
    logic [3:0] r;
  } exp_t;
  exp_t eq[$];
  logic [7:0] q[$];
  int wp, rp, n_chk, n_fail;
  logic [7:0] dout;
  fifo_top dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );
  initial begin
    clk = 1;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", n, act, req, $time);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit f, e;
    exp_t x;
    @(negedge clk);
    wr = w;
    rd = r;
    data_in = d;
    f = q.size() == 8;
    e = q.size() == 0;
    if (r && !e) begin
      dout = q.pop_front();
      rp = (rp + 1) % 16;
    end
    if (w && !f) begin
      q.push_back(d);
      wp = (wp + 1) % 16;
    end
    x.d = dout;
    x.f = q.size() == 8;
    x.e = q.size() == 0;
    x.w = 4'(wp);
    x.r = 4'(rp);
    eq.push_back(x);
  endtask
  task automatic check_reset(input string n);
    chk({n, "_empty"}, 32'(fifo_empty), 1);
    chk({n, "_full"}, 32'(fifo_full), 0);
    chk({n, "_wptr"}, 32'(dut.wptr), 0);
    chk({n, "_rptr"}, 32'(dut.rptr), 0);
    chk({n, "_dout"}, 32'(data_out), 0);
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (eq.size() != 0) begin
      x = eq.pop_front();
      chk("data_out", 32'(data_out), 32'(x.d));
      chk("fifo_full", 32'(fifo_full), 32'(x.f));
      chk("fifo_empty", 32'(fifo_empty), 32'(x.e));
      chk("wptr", 32'(dut.wptr), 32'(x.w));
      chk("rptr", 32'(dut.rptr), 32'(x.r));
    end
  end
  initial begin
    n_chk = 0;
    n_fail = 0;
    wp = 0;
    rp = 0;
    dout = 0;
    rst = 1;
    wr = 0;
    rd = 0;
    data_in = 0;
    #1;
    check_reset("reset");
    #4 rst = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom));
    for (int i = 0; i < 9; i++) step(0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom));
    for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
    step(1, 1, 8'hA5);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      int b = (i / 50) % 2 ? 3 : 7;
      step(($urandom % 10) < b, ($urandom % 10) < 10 - b, 8'($urandom));
    end
    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom));
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
    step(0, 0, 8'h00);
    for (int i = 0; i < 10 && eq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check_reset("async_rst");
    #1 rst = 0;
    q.delete();
    wp = 0;
    rp = 0;
    dout = 0;
    step(1, 0, 8'h3C);
    step(1, 1, 8'hC3);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    for (int i = 0; i < 10 && eq.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
